// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared HUB75 column geometry, column type and fetch state encoding
package hub75_pkg;

    localparam int DEFAULT_ROTATIONAL_RES = 1024;
    localparam int DEFAULT_NUM_ROWS       = 64;
    localparam int DEFAULT_RGB_RES        = 9;

    // Bit-plane bases inside one pixel word: R0-2, G3-5, B6-8
    localparam int R_BASE = 0;
    localparam int G_BASE = 3;
    localparam int B_BASE = 6;

    typedef logic [1:0][DEFAULT_NUM_ROWS-1:0][DEFAULT_RGB_RES-1:0] column_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT
    } state_t;

endpackage

// File: rtl/read_tag_pipe.sv
// rtl/read_tag_pipe.sv - DEPTH-stage {valid, pixel index} delay line matching BRAM read latency
module read_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 6
) (
    input  logic             clk_in,
    input  logic             clr_in,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        valid_d    = valid_q;
        idx_d      = idx_q;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
        if (clr_in) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        valid_q <= valid_d;
        idx_q   <= idx_d;
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/column_fetcher.sv
// rtl/column_fetcher.sv - fetches one display column from frame BRAM and presents it on a valid/ready stream
module column_fetcher
    import hub75_pkg::*;
#(
    parameter int ROTATIONAL_RES = DEFAULT_ROTATIONAL_RES,
    parameter int NUM_ROWS       = DEFAULT_NUM_ROWS,
    parameter int RGB_RES        = DEFAULT_RGB_RES,
    parameter int READ_LATENCY   = 2
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]          theta_in,
    input  logic                                       theta_valid,
    output logic [$clog2(ROTATIONAL_RES*NUM_ROWS)-1:0] mem_addr,
    input  logic [2*RGB_RES-1:0]                       mem_data,
    output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      column_data,
    output logic [$clog2(ROTATIONAL_RES)-1:0]          theta_out,
    output logic                                       tvalid,
    input  logic                                       tready,
    output logic                                       overrun
);

    localparam int THETA_W = $clog2(ROTATIONAL_RES);
    localparam int ADDR_W  = $clog2(ROTATIONAL_RES*NUM_ROWS);
    localparam int IDX_W   = $clog2(NUM_ROWS);
    // Power-of-two rows: the slot base is a shift and the first address issues the
    // cycle after the strobe. Otherwise the product is registered first (arm_q),
    // which delays the first address, and therefore tvalid, by one cycle.
    localparam bit ADDR_IS_SHIFT = ((NUM_ROWS & (NUM_ROWS - 1)) == 0);

    function automatic logic [ADDR_W-1:0] slot_base(input logic [THETA_W-1:0] t);
        return ADDR_W'(t) * ADDR_W'(NUM_ROWS);
    endfunction

    state_t                                 state_q, state_d;
    logic                                   tvalid_q, tvalid_d;
    logic [ADDR_W-1:0]                      mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]                      prod_q, prod_d;
    logic                                   arm_q, arm_d;
    logic                                   issuing_q, issuing_d;
    logic [IDX_W-1:0]                       issue_cnt_q, issue_cnt_d;
    logic [THETA_W-1:0]                     theta_cur_q, theta_cur_d;
    logic [THETA_W-1:0]                     theta_out_q, theta_out_d;
    logic                                   pend_valid_q, pend_valid_d;
    logic [THETA_W-1:0]                     pend_theta_q, pend_theta_d;
    logic                                   overrun_q, overrun_d;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  col_q, col_d;

    logic                                   ret_valid;
    logic [IDX_W-1:0]                       ret_idx;
    logic                                   start;
    logic [THETA_W-1:0]                     start_theta;

    read_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk_in    (clk_in),
        .clr_in    (rst_in),
        .in_valid  (issuing_q),
        .in_idx    (issue_cnt_q),
        .out_valid (ret_valid),
        .out_idx   (ret_idx)
    );

    always_comb begin
        state_d      = state_q;
        tvalid_d     = tvalid_q;
        mem_addr_d   = mem_addr_q;
        prod_d       = prod_q;
        arm_d        = arm_q;
        issuing_d    = issuing_q;
        issue_cnt_d  = issue_cnt_q;
        theta_cur_d  = theta_cur_q;
        theta_out_d  = theta_out_q;
        pend_valid_d = pend_valid_q;
        pend_theta_d = pend_theta_q;
        overrun_d    = overrun_q;
        col_d        = col_q;
        start        = 1'b0;
        start_theta  = theta_in;

        case (state_q)
            ST_IDLE: begin
                if (theta_valid) begin
                    start = 1'b1;
                end
            end
            ST_FETCH: begin
                if (theta_valid) begin
                    overrun_d    = overrun_q | pend_valid_q;
                    pend_valid_d = 1'b1;
                    pend_theta_d = theta_in;
                end
                if (arm_q) begin
                    mem_addr_d  = prod_q;
                    issuing_d   = 1'b1;
                    issue_cnt_d = '0;
                    arm_d       = 1'b0;
                end else if (issuing_q) begin
                    if (issue_cnt_q == IDX_W'(NUM_ROWS - 1)) begin
                        issuing_d = 1'b0;
                    end else begin
                        issue_cnt_d = issue_cnt_q + IDX_W'(1);
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    end
                end
                // Returns landing in a reset cycle belong to the abandoned fetch
                if (ret_valid && !rst_in) begin
                    col_d[0][ret_idx] = mem_data[RGB_RES-1:0];
                    col_d[1][ret_idx] = mem_data[2*RGB_RES-1:RGB_RES];
                    if (ret_idx == IDX_W'(NUM_ROWS - 1)) begin
                        state_d     = ST_PRESENT;
                        tvalid_d    = 1'b1;
                        theta_out_d = theta_cur_q;
                    end
                end
            end
            ST_PRESENT: begin
                if (tvalid_q && tready) begin
                    tvalid_d     = 1'b0;
                    pend_valid_d = 1'b0;
                    if (theta_valid) begin
                        start     = 1'b1;
                        overrun_d = overrun_q | pend_valid_q;
                    end else if (pend_valid_q) begin
                        start       = 1'b1;
                        start_theta = pend_theta_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (theta_valid) begin
                    overrun_d    = overrun_q | pend_valid_q;
                    pend_valid_d = 1'b1;
                    pend_theta_d = theta_in;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d     = ST_FETCH;
            theta_cur_d = start_theta;
            if (ADDR_IS_SHIFT) begin
                mem_addr_d  = slot_base(start_theta);
                issuing_d   = 1'b1;
                issue_cnt_d = '0;
            end else begin
                prod_d = slot_base(start_theta);
                arm_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            tvalid_q     <= 1'b0;
            mem_addr_q   <= '0;
            prod_q       <= '0;
            arm_q        <= 1'b0;
            issuing_q    <= 1'b0;
            issue_cnt_q  <= '0;
            theta_cur_q  <= '0;
            theta_out_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_theta_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tvalid_q     <= tvalid_d;
            mem_addr_q   <= mem_addr_d;
            prod_q       <= prod_d;
            arm_q        <= arm_d;
            issuing_q    <= issuing_d;
            issue_cnt_q  <= issue_cnt_d;
            theta_cur_q  <= theta_cur_d;
            theta_out_q  <= theta_out_d;
            pend_valid_q <= pend_valid_d;
            pend_theta_q <= pend_theta_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk_in) begin
        col_q <= col_d;
    end

    assign mem_addr    = mem_addr_q;
    assign column_data = col_q;
    assign theta_out   = theta_out_q;
    assign tvalid      = tvalid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_column_fetcher.sv
// tb/tb_column_fetcher.sv - directed self-checking bench for column_fetcher
module tb_column_fetcher;
    import hub75_pkg::*;

    localparam int NR = 64;
    localparam int RR = 9;
    localparam int TW = 10;
    localparam int AW = 16;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_in, theta_valid, tready, tready_aux;
    logic [TW-1:0] theta_in;
    logic [AW-1:0] mem_addr, mem_addr1, mem_addr4;
    logic [2*RR-1:0] mem_data, mem_data1, mem_data4;
    column_t       column_data, column_data1, column_data4;
    logic [TW-1:0] theta_out, theta_out1, theta_out4;
    logic          tvalid, tvalid1, tvalid4;
    logic          overrun, overrun1, overrun4;

    int n_checks = 0;
    int n_pass   = 0;

    column_fetcher u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .theta_in(theta_in), .theta_valid(theta_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .column_data(column_data),
        .theta_out(theta_out), .tvalid(tvalid), .tready(tready), .overrun(overrun)
    );

    column_fetcher #(.READ_LATENCY(1)) u_dut_rl1 (
        .clk_in(clk_in), .rst_in(rst_in), .theta_in(theta_in), .theta_valid(theta_valid),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .column_data(column_data1),
        .theta_out(theta_out1), .tvalid(tvalid1), .tready(tready_aux), .overrun(overrun1)
    );

    column_fetcher #(.READ_LATENCY(4)) u_dut_rl4 (
        .clk_in(clk_in), .rst_in(rst_in), .theta_in(theta_in), .theta_valid(theta_valid),
        .mem_addr(mem_addr4), .mem_data(mem_data4), .column_data(column_data4),
        .theta_out(theta_out4), .tvalid(tvalid4), .tready(tready_aux), .overrun(overrun4)
    );

    function automatic logic [2*RR-1:0] bram_word(input logic [AW-1:0] a);
        logic [7:0] th;
        logic [5:0] idx;
        th  = a[13:6];
        idx = a[5:0];
        return {1'b0, th ^ {2'b00, idx}, 3'b000, idx};
    endfunction

    function automatic column_t exp_col(input int th);
        column_t         c;
        logic [2*RR-1:0] w;
        for (int i = 0; i < NR; i++) begin
            w       = bram_word(AW'(th * NR + i));
            c[0][i] = w[RR-1:0];
            c[1][i] = w[2*RR-1:RR];
        end
        return c;
    endfunction

    logic [2*RR-1:0] b2 [2];
    logic [2*RR-1:0] b1;
    logic [2*RR-1:0] b4 [4];
    always @(posedge clk_in) begin
        b2[0] <= bram_word(mem_addr);
        b2[1] <= b2[0];
        b1    <= bram_word(mem_addr1);
        b4[0] <= bram_word(mem_addr4);
        b4[1] <= b4[0];
        b4[2] <= b4[1];
        b4[3] <= b4[2];
    end
    assign mem_data  = b2[1];
    assign mem_data1 = b1;
    assign mem_data4 = b4[3];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_col(input string tag, input column_t obs, input column_t exp);
        int bh, bi;
        bh = 0;
        bi = 0;
        for (int h = 1; h >= 0; h--)
            for (int i = NR - 1; i >= 0; i--)
                if (obs[h][i] !== exp[h][i]) begin
                    bh = h;
                    bi = i;
                end
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s half=%0d pixel=%0d observed=%0h expected=%0h",
                    tag, bh, bi, obs[bh][bi], exp[bh][bi]);
    endtask

    task automatic wait_tvalid(output bit got);
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (tvalid) begin
                got = 1'b1;
                return;
            end
            step();
        end
        got = tvalid;
    endtask

    initial begin
        column_t   cap, cap1, cap4;
        logic [TW-1:0] cap_th;
        int        r2, r1, r4;
        logic      fall_val, walk_ok, stable_ok, col_ok, got, ovr9, ovr10;
        int        deliv [$];

        rst_in = 1'b1; theta_valid = 1'b0; theta_in = '0; tready = 1'b1; tready_aux = 1'b1;
        step(); step(); step();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_theta_out", theta_out, 0);
        chk("rst_overrun", overrun, 0);
        rst_in = 1'b0;

        // Single request, all three latencies
        theta_in = 5; theta_valid = 1'b1;
        r2 = 0; r1 = 0; r4 = 0; fall_val = 1'b1; walk_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 1) theta_valid = 1'b0;
            if (k <= 64 && mem_addr !== AW'(320 + k - 1)) walk_ok = 1'b0;
            if (k == 1) chk("first_addr", mem_addr, 320);
            if (k == 64) chk("last_addr", mem_addr, 383);
            if (r2 != 0 && k == r2 + 1) fall_val = tvalid;
            if (tvalid && r2 == 0) begin r2 = k; cap = column_data; cap_th = theta_out; end
            if (tvalid1 && r1 == 0) begin r1 = k; cap1 = column_data1; end
            if (tvalid4 && r4 == 0) begin r4 = k; cap4 = column_data4; end
        end
        chk("addr_walk", walk_ok, 1);
        chk("latency_rl2", r2, 67);
        chk("latency_rl1", r1, 66);
        chk("latency_rl4", r4, 69);
        chk("tvalid_fall", fall_val, 0);
        chk("theta_out_5", cap_th, 5);
        chk_col("column_5", cap, exp_col(5));
        chk_col("column_5_rl1", cap1, exp_col(5));
        chk_col("column_5_rl4", cap4, exp_col(5));
        chk("plane_r", cap[1][63][R_BASE +: 3], 2);
        chk("plane_g", cap[1][63][G_BASE +: 3], 7);
        chk("plane_b", cap[1][63][B_BASE +: 3], 0);

        // Backpressure for 200 cycles
        tready = 1'b0; theta_in = 20; theta_valid = 1'b1;
        step();
        theta_valid = 1'b0;
        wait_tvalid(got);
        chk("bp_tvalid_rise", got, 1);
        cap = column_data; cap_th = theta_out; stable_ok = 1'b1;
        for (int k = 1; k < 200; k++) begin
            step();
            if (column_data !== cap || theta_out !== cap_th || tvalid !== 1'b1) stable_ok = 1'b0;
        end
        chk("bp_stable", stable_ok, 1);
        chk("bp_theta_out", cap_th, 20);
        chk_col("bp_column", cap, exp_col(20));
        step();
        tready = 1'b1;
        chk("bp_tvalid_at_xfer", tvalid, 1);
        step();
        chk("bp_tvalid_after_xfer", tvalid, 0);

        // Pending overwrite and overrun
        theta_in = 10; theta_valid = 1'b1;
        col_ok = 1'b1; ovr9 = 1'bx; ovr10 = 1'bx;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 9) ovr9 = overrun;
            if (k == 10) ovr10 = overrun;
            if (tvalid && tready) begin
                deliv.push_back(int'(theta_out));
                if (column_data !== exp_col(int'(theta_out))) col_ok = 1'b0;
            end
            theta_valid = (k == 5) || (k == 9);
            theta_in    = (k == 5) ? TW'(11) : TW'(12);
        end
        chk("ovr_before", ovr9, 0);
        chk("ovr_after", ovr10, 1);
        chk("deliv_count", deliv.size(), 2);
        if (deliv.size() >= 2) begin
            chk("deliv_first", deliv[0], 10);
            chk("deliv_second", deliv[1], 12);
        end
        chk("deliv_columns", col_ok, 1);

        // Transfer and new strobe in the same cycle
        rst_in = 1'b1;
        step();
        rst_in = 1'b0; tready = 1'b0; theta_in = 3; theta_valid = 1'b1;
        step();
        theta_valid = 1'b0;
        wait_tvalid(got);
        chk("sim_tvalid_rise", got, 1);
        tready = 1'b1; theta_in = 7; theta_valid = 1'b1;
        step();
        theta_valid = 1'b0;
        chk("sim_tvalid_low", tvalid, 0);
        chk("sim_mem_addr", mem_addr, 448);
        chk("sim_no_overrun", overrun, 0);
        wait_tvalid(got);
        chk("sim_second_rise", got, 1);
        chk("sim_theta_out", theta_out, 7);
        chk_col("sim_column", column_data, exp_col(7));

        // Reset mid-fetch, then fetch slot 0
        step();
        theta_in = 33; theta_valid = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            theta_valid = 1'b0;
        end
        chk("mid_fetch_addr", mem_addr, 33 * 64 + 30);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        theta_in = 0; theta_valid = 1'b1;
        r2 = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            theta_valid = 1'b0;
            if (tvalid && r2 == 0) begin r2 = k; cap = column_data; end
        end
        chk("rst_refetch_latency", r2, 67);
        chk_col("rst_refetch_column", cap, exp_col(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
